// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - Multi-cycle one-bit-per-clock shifter with start/busy/done handshake
// Optional macro: SHIFT_SEQ_EARLY_EXIT_EN (finish early once further steps cannot change the value)
module shift_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        arith,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  cnt;
    logic        dir_q;
    logic        arith_q;
    logic [31:0] step;
    logic        early_exit;

    // Single-bit shift stage; fill bit is the sign only for arithmetic right shifts.
    always_comb begin
        step = work;
        if (!dir_q) begin
            step = {work[30:0], 1'b0};
        end else begin
            step = {arith_q & work[31], work[31:1]};
        end
    end

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    assign early_exit = (work == 32'h0) ||
                        (dir_q && arith_q && (work == 32'hFFFF_FFFF));
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            work    <= 32'h0;
            cnt     <= 5'd0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            result  <= 32'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE for back-to-back issue.
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        work    <= a;
                        cnt     <= shamt;
                        dir_q   <= dir;
                        arith_q <= arith;
                        state   <= S_SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if ((cnt == 5'd0) || early_exit) begin
                        result <= work;
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        work <= step;
                        cnt  <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - Self-checking bench for shift_seq_unit
module tb_shift_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        dir = 1'b0;
    logic        arith = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    shift_seq_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .dir    (dir),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n,
                                              input logic d, input logic ar);
        if (!d) return x << n;
        else if (ar) return $unsigned($signed(x) >>> n);
        else return x >> n;
    endfunction

    // Cycles from acceptance to done.
    function automatic int ref_lat(input logic [31:0] x, input int n,
                                   input logic d, input logic ar);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        logic [31:0] v;
        for (int k = 0; k < n; k++) begin
            v = ref_shift(x, k, d, ar);
            if (v == 32'h0 || (d && ar && v == 32'hFFFF_FFFF)) return k + 1;
        end
`endif
        return n + 1;
    endfunction

    // Reference timeline: acceptance, countdown, completion.
    logic        m_busy, m_done;
    logic [31:0] m_result, m_pending;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_result  <= 32'h0;
            m_pending <= 32'h0;
            m_left    <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pending;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy    <= 1'b1;
                m_left    <= ref_lat(a, int'(shamt), dir, arith);
                m_pending <= ref_shift(a, int'(shamt), dir, arith);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_result", result, m_result);
        end
    end

    // Issues one operation and measures edges from acceptance to done.
    task automatic run_op(input logic [31:0] ia, input logic [4:0] ish, input logic id,
                          input logic iar, input logic [31:0] exp, input int exp_lat,
                          input int inj, input string nm);
        int n;
        @(posedge clk); #1;
        a = ia; shamt = ish; dir = id; arith = iar; start = 1'b1;
        @(posedge clk); #1;
        a = $urandom; shamt = 5'($urandom); dir = ~id; arith = ~iar;
        for (n = 1; n <= 40; n++) begin
            start = (n == inj);
            if (n == inj) a = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            if (done) break;
        end
        start = 1'b0;
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_res"}, result, exp);
    endtask

    initial begin
        int  n;
        bit  seen;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("idle_result", result, 32'h0);

        run_op(32'h0000_0001, 5'd4, 1'b0, 1'b0, 32'h0000_0010, 5, 0, "left4");
        run_op(32'h8000_00F0, 5'd4, 1'b1, 1'b0, 32'h0800_000F, 5, 0, "lsr4");
        run_op(32'h8000_00F0, 5'd4, 1'b1, 1'b1, 32'hF800_000F, 5, 0, "asr4");
        run_op(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1, 0, "sh0");
        run_op(32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 32, 0, "asr31");
        run_op(32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 32, 0, "left31");
        run_op(32'h0000_0001, 5'd8, 1'b0, 1'b0, 32'h0000_0100, 9, 3, "ignore");
        run_op(32'h1234_5678, 5'd12, 1'b1, 1'b0, 32'h0001_2345, 13, 0, "lsr12");
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        run_op(32'h0000_0000, 5'd20, 1'b0, 1'b0, 32'h0000_0000, 1, 0, "early0");
        run_op(32'hFFFF_FF00, 5'd20, 1'b1, 1'b1, 32'hFFFF_FFFF, 9, 0, "early1");
`else
        run_op(32'h0000_0000, 5'd20, 1'b0, 1'b0, 32'h0000_0000, 21, 0, "zero20");
`endif

        // Back-to-back: start presented while done is high.
        @(posedge clk); #1;
        a = 32'h0000_00FF; shamt = 5'd2; dir = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            if (!done) begin @(posedge clk); #1; end
        end
        chk("b2b_first", result, 32'h0000_03FC);
        a = 32'hF000_0000; shamt = 5'd3; dir = 1'b1; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_done", {31'b0, done}, 32'h1);
        chk("b2b_second", result, 32'hFE00_0000);

        // Reset in the middle of a 10-step shift.
        @(posedge clk); #1;
        a = 32'h0000_0003; shamt = 5'd10; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_result", result, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("midrst_nodone", {31'b0, seen}, 32'h0);
        chk("midrst_hold", result, 32'h0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
